multicycle_ctrl: RTL

Multi-cycle control sequencer for the core datapath. Holds the instruction register and steps every instruction through IDLE/FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. It feeds signext with instruction bits [31:7] and the immediate-format select on its alu_op input. It also drives PC, register-file and memory strobes, and handles wait-stated memory handshakes with a timeout trap.

---
 rtl/multicycle_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: holds the instruction register and walks each
// instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, with wait-stated
// memory handshakes that trap after MEM_TIMEOUT cycles without an ack.
module multicycle_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [24:0] instruction,
  output logic [2:0]  alu_op,
  output logic [4:0]  rd_addr,
  output logic [2:0]  funct3,
  input  logic        branch_cond,
  output logic        alu_src_b,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  // Fetched instruction words are 32 bits and a request needs at least one cycle to wait.
  generate
    if (MEM_TIMEOUT < 1 || DATA_WIDTH < 32) begin : g_param_check
      $error("multicycle_ctrl: MEM_TIMEOUT must be >= 1 and DATA_WIDTH >= 32");
    end
  endgenerate

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  // Last cycle a request may still be acked; without an ack the counter would reach MEM_TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP
  } state_t;

  state_t           state_reg, state_next;
  logic [31:0]      ir_reg;
  logic             ir_load;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [1:0]       cause_reg, cause_next;

  logic [6:0] opcode;
  logic       is_load, is_store, is_branch, is_op, is_lui, is_auipc, is_jal, is_jalr, is_opimm;
  logic       opcode_legal;

  assign opcode    = ir_reg[6:0];
  assign is_load   = (opcode == OPC_LOAD);
  assign is_opimm  = (opcode == OPC_OPIMM);
  assign is_auipc  = (opcode == OPC_AUIPC);
  assign is_store  = (opcode == OPC_STORE);
  assign is_op     = (opcode == OPC_OP);
  assign is_lui    = (opcode == OPC_LUI);
  assign is_branch = (opcode == OPC_BRANCH);
  assign is_jalr   = (opcode == OPC_JALR);
  assign is_jal    = (opcode == OPC_JAL);
  assign opcode_legal = is_load | is_opimm | is_auipc | is_store | is_op |
                        is_lui | is_branch | is_jalr | is_jal;

  assign instruction = ir_reg[31:7];
  assign rd_addr     = ir_reg[11:7];
  assign funct3      = ir_reg[14:12];
  assign trap        = (state_reg == S_TRAP);
  assign trap_cause  = cause_reg;

  // Immediate format decoded straight from IR, so it is stable from DECODE until IR is reloaded.
  always_comb begin
    alu_op = 3'd0;
    if (is_store)               alu_op = 3'd1;
    else if (is_branch)         alu_op = 3'd2;
    else if (is_lui | is_auipc) alu_op = 3'd3;
    else if (is_jal)            alu_op = 3'd4;
  end

  // State, instruction register, wait counter and trap cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      ir_reg       <= 32'd0;
      wait_cnt_reg <= '0;
      cause_reg    <= 2'd0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      cause_reg    <= cause_next;
      if (ir_load) ir_reg <= imem_rdata;
    end
  end

  // Next-state and strobe generation.
  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    ir_load    = 1'b0;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    alu_src_b  = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'd0;
    reg_we     = 1'b0;
    wb_sel     = 2'd0;
    case (state_reg)
      S_IDLE: state_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load    = 1'b1;
          state_next = S_DECODE;
        end else if (wait_cnt_reg == CNT_LAST) begin
          state_next = S_TRAP;
          cause_next = CAUSE_IMEM;
        end
      end
      S_DECODE: begin
        if (opcode_legal) begin
          state_next = S_EXECUTE;
        end else begin
          state_next = S_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end
      end
      S_EXECUTE: begin
        alu_src_b = !(is_op | is_branch);
        if (is_branch) begin
          pc_we      = 1'b1;
          pc_src     = branch_cond ? 2'd1 : 2'd0;
          state_next = S_FETCH;
        end else if (is_load | is_store) begin
          state_next = S_MEMORY;
        end else begin
          state_next = S_WRITEBACK;
        end
      end
      S_MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          if (is_store) begin
            pc_we      = 1'b1;
            state_next = S_FETCH;
          end else begin
            state_next = S_WRITEBACK;
          end
        end else if (wait_cnt_reg == CNT_LAST) begin
          state_next = S_TRAP;
          cause_next = CAUSE_DMEM;
        end
      end
      S_WRITEBACK: begin
        reg_we = (rd_addr != 5'd0);
        pc_we  = 1'b1;
        if (is_load)                wb_sel = 2'd1;
        else if (is_jal | is_jalr)  wb_sel = 2'd2;
        else if (is_lui)            wb_sel = 2'd3;
        if (is_jal)                 pc_src = 2'd1;
        else if (is_jalr)           pc_src = 2'd2;
        state_next = S_FETCH;
      end
      S_TRAP: state_next = S_TRAP;
      default: state_next = S_IDLE;
    endcase
  end

  // Wait counter restarts on every state change and counts unacknowledged request cycles.
  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (state_next != state_reg)
      wait_cnt_next = '0;
    else if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack))
      wait_cnt_next = wait_cnt_reg + CNT_W'(1);
  end

endmodule
